// File: rtl/aes_pkg.sv
// Shared AES definitions: round count from key length, key width and
// the keystore state encoding.
package aes_pkg;

  localparam int KEY_W  = 128;
  localparam int NR_MAX = 14;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY,
    READ
  } ks_state_t;

  function automatic int nr_of(input int k);
    return k / 32 + 6;
  endfunction

endpackage

// File: rtl/keystore_if.sv
// Bus between the keystore, the key expander (write side) and the
// cipher round datapath (replay side).
interface keystore_if;
  import aes_pkg::*;

  logic             fill;
  logic             wr_valid;
  logic [KEY_W-1:0] wr_key;
  logic             start;
  logic             decrypt;
  logic             advance;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             last;
  logic             full;

  modport master (
    output fill, wr_valid, wr_key, start, decrypt, advance,
    input  key_out, key_valid, last, full
  );

  modport slave (
    input  fill, wr_valid, wr_key, start, decrypt, advance,
    output key_out, key_valid, last, full
  );

endinterface

// File: rtl/keyregfile.sv
// Round-key register file: one synchronous write port, one asynchronous
// read port. Contents are not reset.
module keyregfile
  import aes_pkg::*;
#(
  parameter int DEPTH = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [KEY_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [KEY_W-1:0]  rdata
);

  logic [KEY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/keystore.sv
// Round-key store: captures NR+1 keys from the expander, then replays
// them forward (encrypt) or backward (decrypt), one per cycle.
module keystore
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input logic       clk,
  input logic       reset,
  keystore_if.slave bus
);

  localparam int               NR       = nr_of(K);
  localparam int               DEPTH    = NR + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NR);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("keystore: K must be 128, 192 or 256");
  end

  ks_state_t         r_state;
  ks_state_t         w_next;
  logic [ADDR_W-1:0] r_wcnt;
  logic [ADDR_W-1:0] r_rptr;
  logic              r_dec;
  logic              w_we;
  logic              w_start_ok;
  logic              w_step;
  logic              w_valid;
  logic              w_last;
  logic [KEY_W-1:0]  w_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // fill overrides every state; a write in the fill cycle is dropped.
  always_comb begin
    w_next     = r_state;
    w_we       = 1'b0;
    w_start_ok = 1'b0;
    w_step     = 1'b0;
    if (bus.fill) begin
      w_next = FILL;
    end else begin
      case (r_state)
        FILL: begin
          if (bus.wr_valid) begin
            w_we = 1'b1;
            if (r_wcnt == LAST_IDX) begin
              w_next = READY;
            end
          end
        end
        READY: begin
          if (bus.start) begin
            w_start_ok = 1'b1;
            w_next     = READ;
          end
        end
        READ: begin
          if (bus.advance) begin
            if (w_last) begin
              w_next = READY;
            end else begin
              w_step = 1'b1;
            end
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt <= '0;
      r_rptr <= '0;
      r_dec  <= 1'b0;
    end else begin
      if (bus.fill) begin
        r_wcnt <= '0;
      end else if (w_we) begin
        r_wcnt <= r_wcnt + 1'b1;
      end

      if (w_start_ok) begin
        r_dec  <= bus.decrypt;
        r_rptr <= bus.decrypt ? LAST_IDX : '0;
      end else if (w_step) begin
        r_rptr <= r_dec ? r_rptr - 1'b1 : r_rptr + 1'b1;
      end
    end
  end

  keyregfile #(
    .DEPTH(DEPTH)
  ) u_regs (
    .clk  (clk),
    .we   (w_we),
    .waddr(r_wcnt),
    .wdata(bus.wr_key),
    .raddr(r_rptr),
    .rdata(w_rdata)
  );

  // Outputs depend only on registered state, never on inputs.
  assign w_valid       = (r_state == READ);
  assign w_last        = w_valid && (r_dec ? (r_rptr == '0) : (r_rptr == LAST_IDX));
  assign bus.key_valid = w_valid;
  assign bus.last      = w_last;
  assign bus.full      = (r_state == READY) || (r_state == READ);
  assign bus.key_out   = w_valid ? w_rdata : '0;

endmodule

// File: tb/tb_keystore.sv
// Bench for keystore: three instances (K=128/192/256) compared every cycle
// against a behavioural model of captured keys and replay position.
module tb_keystore;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         fillD [3];
  logic         wvD   [3];
  logic [127:0] wkD   [3];
  logic         stD   [3];
  logic         decD  [3];
  logic         advD  [3];
  logic [127:0] kOut  [3];
  logic         vOut  [3];
  logic         lOut  [3];
  logic         fOut  [3];

  keystore_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].fill     = fillD[g];
    assign bus[g].wr_valid = wvD[g];
    assign bus[g].wr_key   = wkD[g];
    assign bus[g].start    = stD[g];
    assign bus[g].decrypt  = decD[g];
    assign bus[g].advance  = advD[g];
    assign kOut[g] = bus[g].key_out;
    assign vOut[g] = bus[g].key_valid;
    assign lOut[g] = bus[g].last;
    assign fOut[g] = bus[g].full;

    keystore #(.K(128 + 64 * g)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  // Model: keys captured since the last fill, and replay progress.
  int           nrOf [3] = '{10, 12, 14};
  logic [127:0] slots [3][15];
  int           stored [3];
  bit           capturing [3];
  bit           replayOn [3];
  bit           replayRev [3];
  int           replayPos [3];

  function automatic logic [127:0] rndKey();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      stored[d]    = 0;
      capturing[d] = 1'b0;
      replayOn[d]  = 1'b0;
      replayRev[d] = 1'b0;
      replayPos[d] = 0;
    end
  endtask

  task automatic modelStep(input int d, input bit f, input bit wv, input logic [127:0] wk,
                           input bit st, input bit dec, input bit adv);
    bit isFull;
    isFull = (stored[d] == nrOf[d] + 1);
    if (f) begin
      capturing[d] = 1'b1;
      stored[d]    = 0;
      replayOn[d]  = 1'b0;
    end else begin
      if (capturing[d] && wv && stored[d] < nrOf[d] + 1) begin
        slots[d][stored[d]] = wk;
        stored[d]++;
      end
      if (isFull && !replayOn[d]) begin
        if (st) begin
          replayOn[d]  = 1'b1;
          replayPos[d] = 0;
          replayRev[d] = dec;
        end
      end else if (replayOn[d] && adv) begin
        if (replayPos[d] == nrOf[d]) replayOn[d] = 1'b0;
        else replayPos[d]++;
      end
    end
  endtask

  task automatic checkOutput(input int d);
    logic [127:0] expKey;
    bit expValid, expLast, expFull;
    int k;
    k = 128 + 64 * d;
    expValid = replayOn[d];
    expKey   = expValid ? slots[d][replayRev[d] ? nrOf[d] - replayPos[d] : replayPos[d]] : '0;
    expLast  = expValid && (replayPos[d] == nrOf[d]);
    expFull  = (stored[d] == nrOf[d] + 1);
    vectors++;
    assert (kOut[d] === expKey) else begin
      miscompares++;
      $error("FAIL key_out[K%0d] observed %h expected %h", k, kOut[d], expKey);
    end
    vectors++;
    assert (vOut[d] === expValid) else begin
      miscompares++;
      $error("FAIL key_valid[K%0d] observed %b expected %b", k, vOut[d], expValid);
    end
    vectors++;
    assert (lOut[d] === expLast) else begin
      miscompares++;
      $error("FAIL last[K%0d] observed %b expected %b", k, lOut[d], expLast);
    end
    vectors++;
    assert (fOut[d] === expFull) else begin
      miscompares++;
      $error("FAIL full[K%0d] observed %b expected %b", k, fOut[d], expFull);
    end
  endtask

  task automatic clearInputs();
    for (int d = 0; d < 3; d++) begin
      fillD[d] = 1'b0;
      wvD[d]   = 1'b0;
      wkD[d]   = '0;
      stD[d]   = 1'b0;
      decD[d]  = 1'b0;
      advD[d]  = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int d, input bit f, input bit wv, input logic [127:0] wk,
                               input bit st, input bit dec, input bit adv);
    clearInputs();
    fillD[d] = f;
    wvD[d]   = wv;
    wkD[d]   = wk;
    stD[d]   = st;
    decD[d]  = dec;
    advD[d]  = adv;
    modelStep(d, f, wv, wk, st, dec, adv);
    @(posedge clk);
    #1;
    checkOutput(d);
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) checkOutput(d);
    reset = 1'b0;
  endtask

  task automatic writeKeys(input int d, input int n, input bit seq, input int base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) applyStimulus(d, 0, 0, rndKey(), 0, 0, 0);
      applyStimulus(d, 0, 1, seq ? 128'(base + i) : rndKey(), 0, 0, 0);
    end
  endtask

  task automatic replay(input int d, input bit dec, input int stallAt);
    applyStimulus(d, 0, 0, '0, 1, dec, 1);
    for (int p = 0; p <= nrOf[d]; p++) begin
      if (p == stallAt) repeat (4) applyStimulus(d, 0, 0, '0, 0, 0, 0);
      applyStimulus(d, 0, 0, '0, 0, 0, 1);
    end
    applyStimulus(d, 0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    clearInputs();
    for (int d = 0; d < 3; d++)
      for (int s = 0; s < 15; s++) slots[d][s] = '0;
    doReset();

    // K=128: sequential keys, forward, reverse, then forward with a stalled consumer.
    applyStimulus(0, 1, 0, '0, 0, 0, 0);
    writeKeys(0, 11, 1, 0, 0);
    replay(0, 0, -1);
    replay(0, 1, -1);
    replay(0, 0, 3);

    // K=256: writes with gaps, decrypt replay.
    applyStimulus(2, 1, 0, '0, 0, 0, 0);
    writeKeys(2, 15, 0, 0, 1);
    replay(2, 1, -1);

    // K=192: early start ignored, 14th write dropped.
    applyStimulus(1, 1, 0, '0, 0, 0, 0);
    writeKeys(1, 5, 0, 0, 0);
    applyStimulus(1, 0, 0, '0, 1, 0, 0);
    writeKeys(1, 9, 0, 0, 0);
    replay(1, 0, -1);

    // K=128 abort at replay index 3 with fill+start together, then fill+write together.
    applyStimulus(0, 0, 0, '0, 1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, '0, 0, 0, 1);
    applyStimulus(0, 1, 0, '0, 1, 0, 0);
    applyStimulus(0, 0, 0, '0, 1, 0, 0);
    applyStimulus(0, 1, 1, rndKey(), 0, 0, 0);
    writeKeys(0, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, '0, 1, 0, 0);
    writeKeys(0, 6, 0, 0, 0);
    replay(0, 1, -1);

    // Reset mid-fill, then writes without fill must not capture.
    applyStimulus(1, 1, 0, '0, 0, 0, 0);
    writeKeys(1, 4, 0, 0, 0);
    doReset();
    writeKeys(1, 13, 0, 0, 0);
    applyStimulus(1, 0, 0, '0, 1, 0, 0);

    // Random traffic on every instance.
    for (int d = 0; d < 3; d++) begin
      applyStimulus(d, 1, 0, '0, 0, 0, 0);
      for (int c = 0; c < 400; c++) begin
        applyStimulus(d, $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, rndKey(),
                      $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keystore.md
# keystore

Round-key store between the AES key expander and the cipher round datapath. Captures the stream of NR+1 128-bit round keys as the expander produces them, then replays them one per cycle: in generation order for encryption, or in reverse for decryption. Lets the cipher core run decryption without recomputing the schedule, and lets it re-run either direction on new blocks without re-expanding.

## Interface
- K, 128: key length; legal values 128, 192, 256. NR = K/32+6, giving 10, 12 or 14 rounds. Any other value is an elaboration error.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fill  in  1  pulse; clears the store and starts capture.
- wr_valid  in  1  wr_key holds a valid round key this cycle.
- wr_key  in  128  round key from the expander.
- start  in  1  pulse; begins replay. Honoured only in READY.
- decrypt  in  1  replay direction, sampled on an accepted start. 0 = index 0→NR, 1 = NR→0.
- advance  in  1  consumer took key_out; step to the next key.
- key_out  out  128  current replay key; forced to 0 when key_valid=0.
- key_valid  out  1  key_out is valid.
- last  out  1  key_out is the final key of this replay (index NR when encrypting, 0 when decrypting).
- full  out  1  all NR+1 keys captured; store is replayable.

## Operation
- States: IDLE, FILL, READY, READ.
- IDLE: entered on reset. fill → FILL. All other inputs ignored.
- FILL:
  - Each wr_valid writes wr_key to slot wcnt, then wcnt++.
  - When the write to slot NR occurs → READY, full=1.
  - wr_valid on cycles after that write is ignored.
- READY:
  - start → READ; rptr = decrypt ? NR : 0; the direction is latched.
  - fill → FILL.
  - wr_valid and advance are ignored.
- READ:
  - key_valid=1 and key_out = slot[rptr].
  - advance with last=0: rptr steps ±1 by the latched direction.
  - advance with last=1 → READY. Contents are retained, so start may replay again in either direction.
  - start during READ is ignored.
- fill has priority over everything in every state, including mid-replay and mid-capture:
  - wcnt=0, full=0, key_valid=0 on the next cycle, then FILL.
  - fill and start in the same cycle: fill wins.
  - fill and wr_valid in the same cycle: the write is dropped; capture begins the next cycle.
- Counter widths: wcnt and rptr are 4 bits, which covers slots 0..14.
- Reset behaviour:
  - Outputs: key_valid=0, last=0, full=0, key_out=0.
  - wcnt=0, rptr=0.
  - Slot contents need not be cleared. They are unreachable until a full fill completes.

## Timing
- Writes: wr_valid sampled at edge t is readable from t+1.
- full rises on the cycle after the write to slot NR.
- Replay start: start at edge t gives key_valid=1 with the first key at t+1.
- Replay step: advance at edge t gives the next key at t+1. A consumer holding advance high receives one key per cycle.
- Replay duration: a full replay is NR+1 cycles from the first key_valid. key_valid drops the cycle after the advance on the last key.
- key_out is combinational from the registered rptr through the slot mux. It does not depend combinationally on any input.
- No back-pressure on writes. The expander must not present more than NR+1 keys per fill; any extras are dropped.

## Structure
- Shared package aes_pkg:
  - NR function of K.
  - NR_MAX = 14.
  - keystore statetype enum {IDLE, FILL, READY, READ}.
- Sub-module keyregfile #(DEPTH=NR+1):
  - one write port (we, waddr, wdata);
  - one asynchronous read port (raddr → rdata), 128-bit wide.
- Top module: FSM, wcnt, rptr, direction latch, output gating.

## Test plan
- K=128 encrypt: fill, then 11 writes of 128'h00…00 through 128'h00…0A, then start with decrypt=0 and advance held high. Required: key_out 00…00, 01, …, 0A on consecutive cycles; last=1 only on 0A; then key_valid=0 and the FSM is in READY.
- K=128 decrypt replay of the same store (start with decrypt=1). Required: 0A down to 00; last on 00. Then a second start with decrypt=0 replays in forward order again.
- K=256: 15 keys written with gaps (wr_valid toggling). Required: full rises one cycle after the 15th write; decrypt replay starts at slot 14 value; last after 15 keys.
- Overflow and early start:
  - K=192: 14 writes. Required: the 14th write is ignored; slot 12 keeps the 13th key.
  - start issued while FILL has 5 of 13 keys: ignored, key_valid stays 0.
- Abort cases:
  - fill asserted at replay index 3. Required: key_valid=0 and full=0 next cycle; a subsequent start is ignored until 11 new keys are written.
  - reset mid-FILL. Required: all outputs 0 and the FSM in IDLE.
- Stalled consumer: advance low for 4 cycles during READ. Required: key_out and last hold steady; sequence resumes without skipping when advance returns.
